// File: rtl/multiplicacion_4x4_if.sv
// ============================================================================
// Module : multiplicacion_4x4_if
// Desc   : Operand/product bundle for the array multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multiplicacion_4x4_if #(
   parameter int N = 4
);
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           en;
   logic [2*N-1:0] c;
   logic [2*N-1:0] p_q;
   logic           zero_q;
   logic           ovf_q;

   modport master (
      output a, b, en,
      input  c, p_q, zero_q, ovf_q
   );

   modport slave (
      input  a, b, en,
      output c, p_q, zero_q, ovf_q
   );
endinterface

`default_nettype wire

// File: rtl/multiplicacion_4x4.sv
// ============================================================================
// Module : multiplicacion_4x4
// Desc   : NxN array multiplier, combinational product plus registered copy
//          and zero/overflow flags. MULTIPLICACION_SIGNED_EN selects
//          Baugh-Wooley two's-complement operation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiplicacion_4x4 #(
   parameter int N = 4
) (
   input  wire                   clk,
   input  wire                   rst,
   multiplicacion_4x4_if.slave   bus
);

`ifdef MULTIPLICACION_SIGNED_EN
   // Baugh-Wooley constant: +1 at bit N and at bit 2N-1
   localparam logic [2*N-1:0] C_CORR = {1'b1, {(N-2){1'b0}}, 1'b1, {N{1'b0}}};
`else
   localparam logic [2*N-1:0] C_CORR = '0;
`endif

   logic [N-1:0]   w_pp  [N];
   logic [2*N-1:0] w_row [N];
   logic [2*N-1:0] w_acc [N];
   logic [2*N-1:0] w_cy  [N];
   logic [2*N-1:0] w_prod;
   logic           w_zero;
   logic           w_ovf;

   genvar gi, gj, gk;
   generate
      for (gi = 0; gi < N; gi++) begin : g_pp_row
         for (gj = 0; gj < N; gj++) begin : g_pp_col
`ifdef MULTIPLICACION_SIGNED_EN
            if ((gi == N-1) != (gj == N-1)) begin : g_inv
               assign w_pp[gi][gj] = ~(bus.a[gj] & bus.b[gi]);
            end else begin : g_pos
               assign w_pp[gi][gj] = bus.a[gj] & bus.b[gi];
            end
`else
            assign w_pp[gi][gj] = bus.a[gj] & bus.b[gi];
`endif
         end
         assign w_row[gi] = {{N{1'b0}}, w_pp[gi]} << gi;
      end

      // Row 0 never overlaps the correction bits, so they can be OR-ed in
      assign w_acc[0] = w_row[0] | C_CORR;
      assign w_cy[0]  = '0;

      for (gi = 1; gi < N; gi++) begin : g_add_row
         assign w_cy[gi][0] = 1'b0;
         for (gk = 0; gk < 2*N; gk++) begin : g_fa
            assign w_acc[gi][gk] = w_acc[gi-1][gk] ^ w_row[gi][gk] ^ w_cy[gi][gk];
            if (gk < 2*N-1) begin : g_carry
               assign w_cy[gi][gk+1] = (w_acc[gi-1][gk] & w_row[gi][gk])
                                     | (w_acc[gi-1][gk] & w_cy[gi][gk])
                                     | (w_row[gi][gk]   & w_cy[gi][gk]);
            end
         end
      end
   endgenerate

   assign w_prod = w_acc[N-1];
   assign w_zero = (w_prod == '0);
`ifdef MULTIPLICACION_SIGNED_EN
   assign w_ovf  = (w_prod[2*N-1:N] != {N{w_prod[N-1]}});
`else
   assign w_ovf  = |w_prod[2*N-1:N];
`endif

   assign bus.c = w_prod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.p_q    <= '0;
         bus.zero_q <= 1'b1;
         bus.ovf_q  <= 1'b0;
      end else if (bus.en) begin
         bus.p_q    <= w_prod;
         bus.zero_q <= w_zero;
         bus.ovf_q  <= w_ovf;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multiplicacion_4x4.sv
// ============================================================================
// Module : tb_multiplicacion_4x4
// Desc   : Scoreboard bench for multiplicacion_4x4 (N=4, unsigned build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multiplicacion_4x4;

   localparam int N = 4;

   typedef struct packed {
      logic [2*N-1:0] p;
      logic           z;
      logic           o;
   } exp_t;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;
   exp_t r_sb [$];
   exp_t r_last;

   multiplicacion_4x4_if #(.N(N)) bus ();

   multiplicacion_4x4 #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      int   prod;
      prod = int'(a) * int'(b);
      e.p  = prod[2*N-1:0];
      e.z  = (prod == 0);
      e.o  = (prod >= (1 << N));
      return e;
   endfunction

   // Drive inputs on the falling edge, check c 1 unit later, then check the
   // registered copy 1 unit after the next rising edge.
   task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input logic en, input string tag);
      exp_t e;
      @(negedge clk);
      bus.a  = a;
      bus.b  = b;
      bus.en = en;
      e = model(a, b);
      #1;
      chk({tag, ".c"}, 32'(bus.c), 32'(e.p));
      if (en) r_sb.push_back(e);
      @(posedge clk);
      #1;
      if (en) begin
         if (r_sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(1), 32'(0));
         end else begin
            r_last = r_sb.pop_front();
         end
      end
      chk({tag, ".p_q"},    32'(bus.p_q),    32'(r_last.p));
      chk({tag, ".zero_q"}, 32'(bus.zero_q), 32'(r_last.z));
      chk({tag, ".ovf_q"},  32'(bus.ovf_q),  32'(r_last.o));
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      bus.a   = '0;
      bus.b   = '0;
      bus.en  = 1'b0;
      rst     = 1'b1;
      r_last  = '{p: '0, z: 1'b1, o: 1'b0};

      #2;
      chk("rst.p_q",    32'(bus.p_q),    32'(0));
      chk("rst.zero_q", 32'(bus.zero_q), 32'(1));
      chk("rst.ovf_q",  32'(bus.ovf_q),  32'(0));
      // en is high under reset: registers must stay cleared
      bus.a = 4'hD; bus.b = 4'hA; bus.en = 1'b1;
      @(posedge clk); #1;
      chk("rst_en.p_q", 32'(bus.p_q), 32'(0));
      bus.en = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      step(4'b1101, 4'b1010, 1'b1, "d_x_a");
      chk("d_x_a.lit", 32'(bus.p_q), 32'h82);
      step(4'b1000, 4'b0010, 1'b1, "8_x_2");
      step(4'b1001, 4'b0011, 1'b1, "9_x_3");
      step(4'b1111, 4'b0011, 1'b1, "f_x_3");
      step(4'b0011, 4'b0101, 1'b1, "3_x_5");
      step(4'b0000, 4'b0101, 1'b1, "0_x_5");
      step(4'b0110, 4'b0000, 1'b1, "6_x_0");
      step(4'b1111, 4'b1111, 1'b1, "f_x_f");
      chk("f_x_f.lit", 32'(bus.p_q), 32'hE1);
      step(4'b0111, 4'b0010, 1'b0, "hold1");
      step(4'b0001, 4'b0001, 1'b0, "hold2");

      // Asynchronous reset between edges while p_q is nonzero
      step(4'b1011, 4'b0110, 1'b1, "pre_rst");
      @(negedge clk);
      bus.en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst.p_q",    32'(bus.p_q),    32'(0));
      chk("arst.zero_q", 32'(bus.zero_q), 32'(1));
      chk("arst.ovf_q",  32'(bus.ovf_q),  32'(0));
      chk("arst.c",      32'(bus.c),      32'(8'd66));
      @(posedge clk); #1;
      rst    = 1'b0;
      r_last = '{p: '0, z: 1'b1, o: 1'b0};

      for (int i = 0; i < 256; i++) begin
         step(i[7:4], i[3:0], 1'b1, "sweep");
      end

      if (r_sb.size() != 0) chk("sb_leftover", 32'(r_sb.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multiplicacion_4x4.md
# multiplicacion_4x4

Unsigned N×N array multiplier with a combinational product output and a registered copy of the product and status flags. Used as the multiply element of the arithmetic datapath. Purely combinational consumers read `c` directly. Clocked consumers read the registered outputs, which have one cycle of latency.

## Interface
- `N`, default 4: operand width in bits; the product is 2N bits wide.
- `clk`  in  1: clock; all registers update on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high; clears all registers.
- `a`  in  N: multiplicand.
- `b`  in  N: multiplier.
- `en`  in  1: when high, the registers capture the current product and flags.
- `c`  out  2N: combinational product a×b.
- `p_q`  out  2N: registered product.
- `zero_q`  out  1: registered flag, set when the product is 0.
- `ovf_q`  out  1: registered flag, set when the product does not fit in N bits (any bit of `c[2N-1:N]` set in unsigned mode).

## Operation
- `c = a × b` as an exact 2N-bit result; no truncation or saturation occurs in either mode.
- Structure:
  - N partial-product rows, `pp[i] = b[i] ? a : 0`, each shifted left by i.
  - The rows are summed by ripple-carry rows of full adders (array multiplier).
  - No `*` operator is used, so the adder structure stays explicit.
- On a rising `clk` edge with `en`=1:
  - `p_q <= c`
  - `zero_q <= (c == 0)`
  - `ovf_q <=` overflow condition (defined per mode under Configuration).
- With `en`=0, the registers hold their values.
- `c` depends only on `a` and `b`. It is unaffected by `clk`, `rst` and `en`.

## Timing
- `c` is valid within the combinational settle time after `a` or `b` changes, with zero clock cycles of latency. It must be sampleable 1 time unit after the inputs change in simulation.
- Registered outputs reflect the inputs sampled at the edge where `en`=1, giving a latency of 1 cycle.
- Reset values: `p_q`=0, `zero_q`=1, `ovf_q`=0.
  - Reset applies immediately on the assertion of `rst`, without waiting for a clock edge.
  - Reset overrides `en`.
- Reset mid-operation: `c` keeps tracking the inputs. The first capture after `rst` deasserts is at the first rising edge with `en`=1.
- Boundary cases:
  - `a`=0 or `b`=0 gives `c`=0 and `zero_q`=1 after capture.
  - `a`=`b`=2^N−1 gives `c`=(2^N−1)², which is 0xE1 for N=4, with `ovf_q`=1.

## Configuration
- `MULTIPLICACION_SIGNED_EN` not defined (default): operands and product are unsigned. `ovf_q` is set when `c[2N-1:N]` ≠ 0.
- `MULTIPLICACION_SIGNED_EN` defined:
  - Operands and product are two's complement, implemented with Baugh-Wooley correction (inverted sign partial-product terms and a constant correction).
  - `ovf_q` is set when `c` is not the sign extension of `c[N-1:0]`.
  - Interface and timing are unchanged.
- All test-plan values below apply with the macro undefined.

## Test plan
All scenarios use N=4 with the macro undefined.

- `a`=1101, `b`=1010 -> `c`=10000010 (130) after 1 time unit; capture with `en`=1 -> `p_q`=0x82, `ovf_q`=1, `zero_q`=0.
- `a`=1000, `b`=0010 -> `c`=00010000 (16); capture -> `ovf_q`=1.
- `a`=1001, `b`=0011 -> `c`=00011011 (27).
- `a`=1111, `b`=0011 -> `c`=00101101 (45).
- `a`=0011, `b`=0101 -> `c`=00001111; capture -> `ovf_q`=0. Then `a`=0, then capture -> `p_q`=0, `zero_q`=1. Then `en`=0 with new inputs -> registers hold.
- Assert `rst` between clock edges while `p_q`≠0 -> `p_q`=0, `zero_q`=1, `ovf_q`=0 immediately, while `c` still equals a×b. Then run an exhaustive sweep of all 256 input pairs and check `c` against a reference product.
